alu_seq: RTL and testbench

Sequential, parametrised ALU for the FPGA test designs, generalising the earlier 2-operation 4-bit add/sub unit. It supports 8 operations at `WIDTH` bits and reports carry, overflow, zero and negative flags. Operands and results move over valid/ready handshakes, and the output is a holding register. Multiplication is iterative shift-add (multi-cycle); all other operations complete in one cycle. The block sits between an operand source (switches, UART decoder, test FSM) and a result consumer (LEDs, seven-segment driver).

---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with valid/ready handshakes on both sides.
// MUL runs as a WIDTH-iteration shift-add; every other op finishes on the accepting edge.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;
    logic                 shift_big;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 accept;
    logic                 load;
    logic [WIDTH-1:0]     load_res;
    logic                 load_c;
    logic                 load_v;

    assign sum_w     = {1'b0, a} + {1'b0, b};
    assign diff_w    = {1'b0, a} - {1'b0, b};
    assign shift_big = ((WIDTH+1)'(b) >= (WIDTH+1)'(WIDTH));
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle datapath; MUL is handled by the iterative path below.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = diff_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: alu_res = shift_big ? '0 : (a << b);
            OP_SHR: alu_res = shift_big ? '0 : (a >> b);
            default: alu_res = '0;
        endcase
    end

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q && !out_ready;
        load        = 1'b0;
        load_res    = alu_res;
        load_c      = alu_c;
        load_v      = alu_v;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_IDLE;
                    load     = 1'b1;
                    load_res = acc_step[WIDTH-1:0];
                    load_c   = |acc_step[2*WIDTH-1:WIDTH];
                    load_v   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A load wins over a same-edge drain, so out_valid stays high with the new result.
        if (load) begin
            result_d    = load_res;
            carry_d     = load_c;
            ovf_d       = load_v;
            zero_d      = (load_res == '0);
            neg_d       = load_res[WIDTH-1];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4: expected results are queued on accept
// and compared when the consumer takes each result.
module tb_alu_seq;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         busy;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int a;
        int b;
        int res;
        int c;
        int v;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - (1 << W) : x;
    endfunction

    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int   s;
        e.op = o; e.a = x; e.b = y; e.c = 0; e.v = 0; e.res = 0;
        case (o)
            0: begin
                s = x + y; e.res = s & MASK; e.c = (s > MASK) ? 1 : 0;
                s = sgn(x) + sgn(y); e.v = (s >= HALF || s < -HALF) ? 1 : 0;
            end
            1: begin
                e.res = (x - y) & MASK; e.c = (x < y) ? 1 : 0;
                s = sgn(x) - sgn(y); e.v = (s >= HALF || s < -HALF) ? 1 : 0;
            end
            2: e.res = x & y;
            3: e.res = x | y;
            4: e.res = x ^ y;
            5: e.res = (y >= W) ? 0 : ((x << y) & MASK);
            6: e.res = (y >= W) ? 0 : (x >> y);
            default: begin
                s = x * y; e.res = s & MASK; e.c = (s > MASK) ? 1 : 0;
            end
        endcase
        return e;
    endfunction

    // Monitor: handshakes are sampled mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    $display("op=%0d a=%0d b=%0d -> result=%0d c=%0d v=%0d z=%0d n=%0d",
                             e.op, e.a, e.b, result, carry, overflow, zero, negative);
                    chk("sb_result",   32'(result),   32'(e.res));
                    chk("sb_carry",    32'(carry),    32'(e.c));
                    chk("sb_overflow", 32'(overflow), 32'(e.v));
                    chk("sb_zero",     32'(zero),     (e.res == 0) ? 32'(1) : 32'(0));
                    chk("sb_negative", 32'(negative), (e.res >= HALF) ? 32'(1) : 32'(0));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(int'(op), int'(a), int'(b)));
        end
    end

    // Present one op and return #1 after the edge that accepted it.
    task automatic send(input int o, input int x, input int y);
        int guard;
        bit acc;
        guard = 0;
        acc   = 1'b0;
        op = 3'(o); a = W'(x); b = W'(y); in_valid = 1'b1;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) chk("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_result",    32'(result),    32'(0));
        chk("rst_carry",     32'(carry),     32'(0));
        chk("rst_overflow",  32'(overflow),  32'(0));
        chk("rst_zero",      32'(zero),      32'(0));
        chk("rst_negative",  32'(negative),  32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_in_ready",  32'(in_ready),  32'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(0, 7, 9);
        chk("add_wrap_valid",  32'(out_valid), 32'(1));
        chk("add_wrap_result", 32'(result),    32'(0));
        chk("add_wrap_carry",  32'(carry),     32'(1));
        chk("add_wrap_zero",   32'(zero),      32'(1));
        send(0, 7, 1);
        chk("add_ovf_flag", 32'(overflow), 32'(1));
        chk("add_ovf_neg",  32'(negative), 32'(1));
        send(1, 3, 5);
        send(5, 3, 2);
        send(6, 12, 5);
        send(4, 10, 6);
        send(2, 12, 10);
        send(3, 12, 10);
        send(5, 9, 15);

        c0 = cyc;
        for (int i = 0; i < 6; i++) send(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        chk("b2b_cycles", 32'(cyc - c0), 32'(6));

        send(7, 5, 3);
        n = 0;
        while (busy && n < 20) begin
            chk("mul_in_ready", 32'(in_ready), 32'(0));
            n++;
            @(posedge clk);
            #1;
        end
        chk("mul_busy_cycles", 32'(n), 32'(4));
        chk("mul_done_valid",  32'(out_valid), 32'(1));
        send(7, 6, 7);
        chk("mul_after_accept_busy", 32'(busy), 32'(1));

        for (int i = 0; i < 14; i++)
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        repeat (8) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(0, 2, 3);
        op = 3'd2; a = W'(12); b = W'(10); in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid",    32'(out_valid), 32'(1));
            chk("hold_result",   32'(result),    32'(5));
            chk("hold_carry",    32'(carry),     32'(0));
            chk("hold_in_ready", 32'(in_ready),  32'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release_result", 32'(result),    32'(8));
        chk("release_valid",  32'(out_valid), 32'(1));

        send(7, 6, 7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_result",    32'(result),    32'(0));
        chk("abort_carry",     32'(carry),     32'(0));
        chk("abort_overflow",  32'(overflow),  32'(0));
        chk("abort_zero",      32'(zero),      32'(0));
        chk("abort_negative",  32'(negative),  32'(0));
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_busy",      32'(busy),      32'(0));
        chk("abort_in_ready",  32'(in_ready),  32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 2, 2);
        chk("post_abort_result", 32'(result), 32'(4));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
